seq_pair_order_checker: RTL and testbench

// Synthesizable, parametrised checker for ordered seq1 -> seq2 transactions, usable in emulation/FPGA.
// seq1 = rose(a) then first b within [ANT_MIN:ANT_MAX] cycles; seq2 = c next cycle, then d in [CON_MIN:CON_MAX].
// Up to NSLOT seq2 attempts are tracked concurrently and must complete in antecedent (tag) order.

---
 rtl/seq_pair_pkg.sv | 23 ++
 rtl/seq_pair_slot.sv | 88 ++++++++
 rtl/seq_pair_order_checker.sv | 158 +++++++++++++++
 tb/tb_seq_pair_order_checker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pair_pkg.sv
// Shared types for the seq1 -> seq2 ordered pair checker.
// Slot states, antecedent engine states and fail codes.
package seq_pair_pkg;

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_WAIT_C = 2'd1,
    S_WAIT_D = 2'd2
  } slot_state_e;

  typedef enum logic {
    ANT_IDLE  = 1'b0,
    ANT_ARMED = 1'b1
  } ant_state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_NO_C    = 2'd1,
    FC_TIMEOUT = 2'd2,
    FC_MULTI   = 2'd3
  } fail_code_e;

endpackage

// File: rtl/seq_pair_slot.sv
// One consequent tracker: waits for c the cycle after allocation, then for d
// inside [CON_MIN:CON_MAX], passing only when its tag is next in order.
module seq_pair_slot
  import seq_pair_pkg::*;
#(
  parameter int unsigned CON_MIN = 2,
  parameter int unsigned CON_MAX = 10,
  parameter int unsigned TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             c,
  input  logic             d,
  input  logic [TAG_W-1:0] co_tag,
  output logic             occupied_c,
  output logic             pass_req_c,
  output logic             fail_req_c,
  output fail_code_e       code_c,
  output logic [TAG_W-1:0] tag
);

  localparam int unsigned CNT_W = $clog2(CON_MAX + 1);

  slot_state_e      state;
  logic [CNT_W-1:0] cnt;

  assign occupied_c = (state != S_FREE);

  // Retirement decision for the current cycle; cnt already holds cycles since c.
  always_comb begin
    pass_req_c = 1'b0;
    fail_req_c = 1'b0;
    code_c     = FC_NONE;
    case (state)
      S_WAIT_C: begin
        if (!c) begin
          fail_req_c = 1'b1;
          code_c     = FC_NO_C;
        end
      end
      S_WAIT_D: begin
        if (d && (cnt >= CNT_W'(CON_MIN)) && (tag == co_tag)) begin
          pass_req_c = 1'b1;
        end else if (cnt == CNT_W'(CON_MAX)) begin
          fail_req_c = 1'b1;
          code_c     = FC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FREE;
      tag   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_FREE: begin
          if (alloc) begin
            state <= S_WAIT_C;
            tag   <= alloc_tag;
          end
        end
        S_WAIT_C: begin
          if (c) begin
            state <= S_WAIT_D;
            cnt   <= CNT_W'(1);
          end else begin
            state <= S_FREE;
          end
        end
        S_WAIT_D: begin
          if (pass_req_c || fail_req_c) begin
            state <= S_FREE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: rtl/seq_pair_order_checker.sv
// Ordered seq1 -> seq2 checker: antecedent engine allocates tagged slots,
// slots must retire in tag order; results reported as registered pulses.
module seq_pair_order_checker
  import seq_pair_pkg::*;
#(
  parameter int unsigned ANT_MIN = 1,
  parameter int unsigned ANT_MAX = 5,
  parameter int unsigned CON_MIN = 2,
  parameter int unsigned CON_MAX = 10,
  parameter int unsigned NSLOT   = 4,
  parameter int unsigned TAG_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a,
  input  logic                         b,
  input  logic                         c,
  input  logic                         d,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   fail_code,
  output logic [TAG_W-1:0]             pass_tag,
  output logic [TAG_W-1:0]             an_tag,
  output logic [TAG_W-1:0]             co_tag,
  output logic                         ant_drop,
  output logic                         ant_miss,
  output logic [$clog2(NSLOT+1)-1:0]   busy
);

  localparam int unsigned BUSY_W = $clog2(NSLOT + 1);
  localparam int unsigned AGE_W  = $clog2(ANT_MAX + 1);

  ant_state_e       ant_state;
  logic [AGE_W-1:0] age;
  logic             a_q;
  logic             rose_c;
  logic             match_c;
  logic             miss_c;

  logic [NSLOT-1:0] occ;
  logic [NSLOT-1:0] occ_next;
  logic [NSLOT-1:0] alloc;
  logic [NSLOT-1:0] pass_req;
  logic [NSLOT-1:0] fail_req;
  logic [TAG_W-1:0] slot_tag  [NSLOT];
  fail_code_e       slot_code [NSLOT];

  logic              found;
  logic [BUSY_W-1:0] npass;
  logic [BUSY_W-1:0] nfail;
  logic [BUSY_W-1:0] busy_next;
  logic [TAG_W-1:0]  ptag;
  fail_code_e        fcode;

  assign rose_c  = a & ~a_q;
  assign match_c = (ant_state == ANT_ARMED) && b && (age >= AGE_W'(ANT_MIN));
  assign miss_c  = (ant_state == ANT_ARMED) && !match_c && (age == AGE_W'(ANT_MAX));

  // Antecedent engine; age counts cycles since rose(a), first evaluated as 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ant_state <= ANT_IDLE;
      age       <= '0;
      a_q       <= 1'b0;
    end else begin
      a_q <= a;
      case (ant_state)
        ANT_IDLE: begin
          if (rose_c) begin
            ant_state <= ANT_ARMED;
            age       <= AGE_W'(1);
          end
        end
        ANT_ARMED: begin
          if (match_c || miss_c) begin
            ant_state <= ANT_IDLE;
          end else begin
            age <= age + AGE_W'(1);
          end
        end
        default: ant_state <= ANT_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    seq_pair_slot #(
      .CON_MIN (CON_MIN),
      .CON_MAX (CON_MAX),
      .TAG_W   (TAG_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .alloc      (alloc[g]),
      .alloc_tag  (an_tag),
      .c          (c),
      .d          (d),
      .co_tag     (co_tag),
      .occupied_c (occ[g]),
      .pass_req_c (pass_req[g]),
      .fail_req_c (fail_req[g]),
      .code_c     (slot_code[g]),
      .tag        (slot_tag[g])
    );
  end

  // Lowest-free allocation and retirement tally; slots freed now are not reusable this cycle.
  always_comb begin
    alloc     = '0;
    occ_next  = '0;
    found     = 1'b0;
    npass     = '0;
    nfail     = '0;
    busy_next = '0;
    ptag      = '0;
    fcode     = FC_NONE;
    for (int i = 0; i < NSLOT; i++) begin
      if (!occ[i] && !found) begin
        found    = 1'b1;
        alloc[i] = match_c;
      end
    end
    for (int i = 0; i < NSLOT; i++) begin
      npass       = npass + BUSY_W'(pass_req[i]);
      nfail       = nfail + BUSY_W'(fail_req[i]);
      occ_next[i] = (occ[i] & ~(pass_req[i] | fail_req[i])) | alloc[i];
      busy_next   = busy_next + BUSY_W'(occ_next[i]);
      if (pass_req[i]) ptag = slot_tag[i];
      if (fail_req[i]) fcode = slot_code[i];
    end
    if (nfail > BUSY_W'(1)) fcode = FC_MULTI;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'd0;
      pass_tag  <= '0;
      an_tag    <= '0;
      co_tag    <= '0;
      ant_drop  <= 1'b0;
      ant_miss  <= 1'b0;
      busy      <= '0;
    end else begin
      pass      <= (npass != '0);
      fail      <= (nfail != '0);
      fail_code <= 2'(fcode);
      pass_tag  <= ptag;
      ant_drop  <= match_c & ~found;
      ant_miss  <= miss_c;
      busy      <= busy_next;
      if (match_c && found) an_tag <= an_tag + TAG_W'(1);
      co_tag    <= co_tag + TAG_W'(npass) + TAG_W'(nfail);
    end
  end

endmodule

// File: tb/tb_seq_pair_order_checker.sv
// Table-driven bench for seq_pair_order_checker: per-cycle stimulus rows with
// hand-derived expected outputs, checked through an expectation queue.
module tb_seq_pair_order_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic       pass, fail, ant_drop, ant_miss;
  logic [1:0] fail_code;
  logic [7:0] pass_tag, an_tag, co_tag;
  logic [2:0] busy;

  typedef struct packed {
    logic       p;
    logic       f;
    logic [1:0] code;
    logic [7:0] ptag;
    logic       miss;
    logic       drop;
    logic [2:0] busy;
    logic [7:0] an;
    logic [7:0] co;
  } obs_t;

  typedef struct {
    string lbl;
    logic  rst, a, b, c, d;
    obs_t  exp;
  } vec_t;

  vec_t  tbl[$];
  obs_t  sb[$];
  string lbl = "init";
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  seq_pair_order_checker dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .pass      (pass),
    .fail      (fail),
    .fail_code (fail_code),
    .pass_tag  (pass_tag),
    .an_tag    (an_tag),
    .co_tag    (co_tag),
    .ant_drop  (ant_drop),
    .ant_miss  (ant_miss),
    .busy      (busy)
  );

  task automatic v(input logic r, ia, ib, ic, id, p, f, input logic [1:0] code,
                   input logic [7:0] ptag, input logic miss, drop,
                   input logic [2:0] bsy, input logic [7:0] an, co);
    vec_t e;
    e.lbl = lbl;
    e.rst = r; e.a = ia; e.b = ib; e.c = ic; e.d = id;
    e.exp = '{p: p, f: f, code: code, ptag: ptag, miss: miss, drop: drop,
              busy: bsy, an: an, co: co};
    tbl.push_back(e);
  endtask

  task automatic hold(input int n, input logic ia, input logic [2:0] bsy,
                      input logic [7:0] an, co);
    for (int i = 0; i < n; i++) v(0, ia, 0, 0, 0, 0, 0, 0, 0, 0, 0, bsy, an, co);
  endtask

  task automatic rstv();
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic string fmt(input obs_t o);
    return $sformatf("p=%0d f=%0d code=%0d ptag=%0d miss=%0d drop=%0d busy=%0d an=%0d co=%0d",
                     o.p, o.f, o.code, o.ptag, o.miss, o.drop, o.busy, o.an, o.co);
  endfunction

  initial begin
    lbl = "reset"; rstv();

    // b two cycles after rose(a), c, d at cnt=3 -> pass tag0
    lbl = "s1_pass";
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    hold(2, 0, 1, 1, 0);
    v(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    hold(1, 0, 0, 1, 1);
    rstv();

    // b one cycle too late -> ant_miss, nothing allocated
    lbl = "s2_miss";
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hold(4, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstv();

    // no c after match -> NO_C
    lbl = "s3_no_c";
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
    hold(1, 0, 0, 1, 1);
    rstv();

    // d at cnt=1 too early, then timeout at cnt=CON_MAX
    lbl = "s4_timeout";
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hold(1, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    hold(8, 0, 1, 1, 0);
    v(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 1);
    hold(1, 0, 0, 1, 1);
    rstv();

    // tag0 times out, then tag1 becomes current and passes on next d
    lbl = "s5_order_timeout";
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    hold(7, 0, 2, 2, 0);
    v(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 1);
    v(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 2, 2);
    hold(1, 0, 0, 2, 2);
    rstv();

    // d valid for both: only tag0 passes, tag1 keeps waiting and passes next d
    lbl = "s5_order_same_d";
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    hold(2, 0, 2, 2, 0);
    v(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2, 1);
    v(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 2, 2);
    hold(1, 0, 0, 2, 2);
    rstv();

    // held a cannot re-rise; miss; timeout and NO_C in one cycle -> MULTI
    lbl = "s7_multi";
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    hold(4, 1, 1, 1, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    hold(2, 0, 1, 1, 0);
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    v(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 2, 2);
    hold(1, 0, 0, 2, 2);
    rstv();

    // fifth match with all slots busy -> drop; reset discards silently
    lbl = "s6_drop_reset";
    v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0);
    v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 0);
    v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4, 4, 0);
    v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    rstv();
    hold(4, 0, 0, 0, 0);

    for (int r = 0; r < tbl.size(); r++) begin
      obs_t got, exp;
      @(negedge clk);
      rst = tbl[r].rst;
      a   = tbl[r].a;
      b   = tbl[r].b;
      c   = tbl[r].c;
      d   = tbl[r].d;
      sb.push_back(tbl[r].exp);
      @(posedge clk);
      #1;
      got = '{p: pass, f: fail, code: fail_code, ptag: pass_tag, miss: ant_miss,
              drop: ant_drop, busy: busy, an: an_tag, co: co_tag};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s row %0d: got {%s} expected {%s}", tbl[r].lbl, r, fmt(got), fmt(exp));
      end
    end

    checks++;
    if (busy !== 3'd0) begin
      errors++;
      $display("FAIL final: busy=%0d expected 0", busy);
    end
    checks++;
    if (an_tag !== 8'd0) begin
      errors++;
      $display("FAIL final: an_tag=%0d expected 0", an_tag);
    end
    checks++;
    if (co_tag !== 8'd0) begin
      errors++;
      $display("FAIL final: co_tag=%0d expected 0", co_tag);
    end
    checks++;
    if (pass !== 1'b0) begin
      errors++;
      $display("FAIL final: pass=%0d expected 0", pass);
    end
    checks++;
    if (fail !== 1'b0) begin
      errors++;
      $display("FAIL final: fail=%0d expected 0", fail);
    end
    checks++;
    if (ant_drop !== 1'b0) begin
      errors++;
      $display("FAIL final: ant_drop=%0d expected 0", ant_drop);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
